// File: rtl/amo_sequencer_pkg.sv
// Shared types for the RV32A atomic sequencer: fn5 encodings, FSM states and
// the LR/SC reservation record.
package amo_sequencer_pkg;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_t;

    localparam logic [4:0] AMO_LR_FN5 = AMO_LR;
    localparam logic [4:0] AMO_SC_FN5 = AMO_SC;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_WAIT,
        SC_CHECK,
        STORE,
        DONE
    } amo_seq_state_t;

    typedef struct packed {
        logic        valid;
        logic [29:0] addr;
    } amo_reservation_t;

endpackage

// File: rtl/amo_sequencer_if.sv
// Issue, data-memory, writeback and coherence signals of the atomic sequencer.
// The sequencer takes the slave view; the surrounding pipeline takes master.
interface amo_sequencer_if #(parameter int ID_W = 3);

    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_op;
    logic [31:0]     req_addr;
    logic [31:0]     req_rs2;
    logic [ID_W-1:0] req_id;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [31:0]     mem_req_addr;
    logic [31:0]     mem_req_wdata;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_rdata;

    logic            done_valid;
    logic            done_ready;
    logic [31:0]     done_rd;
    logic [ID_W-1:0] done_id;

    logic            snoop_valid;
    logic [31:0]     snoop_addr;
    logic            flush;

    modport master (
        output req_valid, req_op, req_addr, req_rs2, req_id,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output done_ready, snoop_valid, snoop_addr, flush,
        input  req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  done_valid, done_rd, done_id
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_rs2, req_id,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  done_ready, snoop_valid, snoop_addr, flush,
        output req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output done_valid, done_rd, done_id
    );

endinterface

// File: rtl/amo_sequencer_alu.sv
// Combinational AMO operator: new memory value from (fn5, old value, rs2).
// Unlisted fn5 codes, including LR/SC, fall back to SWAP.
module amo_alu
    import amo_sequencer_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] mem_data,
    input  logic [31:0] rs2,
    output logic [31:0] result
);

    // NOTE: result takes a default before the case so no path leaves it unassigned.
    always_comb begin
        result = rs2;
        case (op)
            AMO_ADD:  result = mem_data + rs2;
            AMO_XOR:  result = mem_data ^ rs2;
            AMO_AND:  result = mem_data & rs2;
            AMO_OR:   result = mem_data | rs2;
            AMO_MIN:  result = ($signed(mem_data) < $signed(rs2)) ? mem_data : rs2;
            AMO_MAX:  result = ($signed(mem_data) > $signed(rs2)) ? mem_data : rs2;
            AMO_MINU: result = (mem_data < rs2) ? mem_data : rs2;
            AMO_MAXU: result = (mem_data > rs2) ? mem_data : rs2;
            default:  result = rs2;
        endcase
    end

endmodule

// File: rtl/amo_sequencer.sv
// RV32A read-modify-write sequencer: owns the data-memory port for the length
// of one atomic and holds the LR/SC reservation.
module amo_sequencer
    import amo_sequencer_pkg::*;
#(
    parameter int ID_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    amo_sequencer_if.slave bus
);

    amo_seq_state_t   state;
    amo_reservation_t resv;

    logic [4:0]      op_q;
    logic [29:0]     addr_q;
    logic [31:0]     rs2_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     old_q;

    logic            mem_valid_q;
    logic            mem_we_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic            done_valid_q;
    logic [31:0]     done_rd_q;
    logic [ID_W-1:0] done_id_q;

    logic [31:0] alu_result;
    logic        snoop_resv_hit;
    logic        snoop_req_hit;
    logic        sc_ok;
    logic        unused_addr_lsbs;

    amo_alu u_alu (
        .op       (op_q),
        .mem_data (bus.mem_rsp_rdata),
        .rs2      (rs2_q),
        .result   (alu_result)
    );

    assign snoop_resv_hit   = bus.snoop_valid && (bus.snoop_addr[31:2] == resv.addr);
    assign snoop_req_hit    = bus.snoop_valid && (bus.snoop_addr[31:2] == addr_q);
    assign sc_ok            = resv.valid && (resv.addr == addr_q) && !snoop_req_hit;
    assign unused_addr_lsbs = ^{bus.req_addr[1:0], bus.snoop_addr[1:0]};

    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_we    = mem_we_q;
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.mem_req_wdata = mem_wdata_q;
    assign bus.done_valid    = done_valid_q;
    assign bus.done_rd       = done_rd_q;
    assign bus.done_id       = done_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resv         <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            rs2_q        <= '0;
            id_q         <= '0;
            old_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_valid_q <= 1'b0;
            done_rd_q    <= '0;
            done_id_q    <= '0;
        end else begin
            // NOTE: non-blocking, so a later assignment in the case below (LR set,
            // SC exit) overrides this background clear for the same cycle.
            if (bus.flush || snoop_resv_hit)
                resv.valid <= 1'b0;

            case (state)
                IDLE: if (bus.req_valid) begin
                    op_q   <= bus.req_op;
                    addr_q <= bus.req_addr[31:2];
                    rs2_q  <= bus.req_rs2;
                    id_q   <= bus.req_id;
                    if (bus.req_op == AMO_SC_FN5) begin
                        state <= SC_CHECK;
                    end else begin
                        state       <= LOAD;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                    end
                end
                LOAD: if (bus.mem_req_ready) begin
                    mem_valid_q <= 1'b0;
                    state       <= LOAD_WAIT;
                end
                LOAD_WAIT: if (bus.mem_rsp_valid) begin
                    old_q       <= bus.mem_rsp_rdata;
                    mem_wdata_q <= alu_result;
                    if (op_q == AMO_LR_FN5) begin
                        // A snoop or flush landing with the LR leaves no reservation.
                        resv.valid   <= !(bus.flush || snoop_req_hit);
                        resv.addr    <= addr_q;
                        done_valid_q <= 1'b1;
                        done_rd_q    <= bus.mem_rsp_rdata;
                        done_id_q    <= id_q;
                        state        <= DONE;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b1;
                        state       <= STORE;
                    end
                end
                SC_CHECK: begin
                    resv.valid <= 1'b0;
                    if (sc_ok) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {addr_q, 2'b00};
                        mem_wdata_q <= rs2_q;
                        state       <= STORE;
                    end else begin
                        done_valid_q <= 1'b1;
                        done_rd_q    <= 32'd1;
                        done_id_q    <= id_q;
                        state        <= DONE;
                    end
                end
                STORE: if (bus.mem_req_ready) begin
                    mem_valid_q  <= 1'b0;
                    mem_we_q     <= 1'b0;
                    done_valid_q <= 1'b1;
                    done_rd_q    <= (op_q == AMO_SC_FN5) ? 32'd0 : old_q;
                    done_id_q    <= id_q;
                    state        <= DONE;
                end
                DONE: if (bus.done_ready) begin
                    done_valid_q <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: stimulus queues expected loads, stores and
// results; memory and writeback monitors pop and compare as the DUT presents them.
module tb_amo_sequencer;
    import amo_sequencer_pkg::*;

    localparam int ID_W = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    typedef struct {
        logic [31:0]     rd;
        logic [ID_W-1:0] id;
    } dn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    amo_sequencer_if #(.ID_W(ID_W)) bus ();
    amo_sequencer #(.ID_W(ID_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [logic [31:0]];
    st_t         exp_st [$];
    logic [31:0] exp_ld [$];
    dn_t         exp_dn [$];

    int load_stall  = 0;
    int store_stall = 0;
    int done_stall  = 0;
    int rsp_delay   = 1;
    int done_seen   = 0;
    int done_target = 0;
    int accept_cyc  = 0;
    int st_cyc      = 0;
    int dn_cyc      = 0;
    bit load_pending = 1'b0;
    logic [ID_W-1:0] next_id = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event or wait budget expired", name);
    endtask

    // Memory model: applies stalls, checks request stability, answers loads.
    initial begin : mem_model
        int          rsp_cnt;
        logic [31:0] rsp_data;
        bit          hold;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        st_t         s;
        logic [31:0] la;
        rsp_cnt = 0; rsp_data = '0; hold = 1'b0;
        h_addr = '0; h_wdata = '0; h_we = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            if (load_pending) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_rdata = rsp_data;
                    load_pending = 1'b0;
                end
            end
            if (bus.mem_req_valid === 1'b1) begin
                if (hold) begin
                    check("mem_req_addr stable", bus.mem_req_addr, h_addr);
                    check("mem_req_we stable", 32'(bus.mem_req_we), 32'(h_we));
                    check("mem_req_wdata stable", bus.mem_req_wdata, h_wdata);
                end
                if (!bus.mem_req_we && load_stall > 0) begin
                    bus.mem_req_ready = 1'b0;
                    load_stall--;
                end else if (bus.mem_req_we && store_stall > 0) begin
                    bus.mem_req_ready = 1'b0;
                    store_stall--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                end
                if (!bus.mem_req_ready) begin
                    check("req_ready low in mem stall", 32'(bus.req_ready), 32'd0);
                    hold = 1'b1;
                    h_addr = bus.mem_req_addr; h_we = bus.mem_req_we; h_wdata = bus.mem_req_wdata;
                end else begin
                    hold = 1'b0;
                    if (!bus.mem_req_we) begin
                        if (exp_ld.size() == 0) fail_evt("unexpected load");
                        else begin
                            la = exp_ld.pop_front();
                            check("load addr", bus.mem_req_addr, la);
                        end
                        rsp_data = mem.exists(bus.mem_req_addr) ? mem[bus.mem_req_addr] : 32'd0;
                        rsp_cnt = rsp_delay;
                        load_pending = 1'b1;
                    end else begin
                        if (exp_st.size() == 0) fail_evt("unexpected store");
                        else begin
                            s = exp_st.pop_front();
                            check("store addr", bus.mem_req_addr, s.addr);
                            check("store data", bus.mem_req_wdata, s.data);
                        end
                        mem[bus.mem_req_addr] = bus.mem_req_wdata;
                        st_cyc = cyc;
                    end
                end
            end else begin
                bus.mem_req_ready = 1'b1;
                hold = 1'b0;
            end
        end
    end

    // Writeback monitor: applies done backpressure and scores results.
    initial begin : done_mon
        dn_t             e;
        bit              hold;
        logic [31:0]     h_rd;
        logic [ID_W-1:0] h_id;
        hold = 1'b0; h_rd = '0; h_id = '0;
        bus.done_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.done_valid === 1'b1) begin
                if (hold) begin
                    check("done_rd stable", bus.done_rd, h_rd);
                    check("done_id stable", 32'(bus.done_id), 32'(h_id));
                end
                if (done_stall > 0) begin
                    bus.done_ready = 1'b0;
                    done_stall--;
                    check("req_ready low in done stall", 32'(bus.req_ready), 32'd0);
                    hold = 1'b1; h_rd = bus.done_rd; h_id = bus.done_id;
                end else begin
                    bus.done_ready = 1'b1;
                    hold = 1'b0;
                    if (exp_dn.size() == 0) fail_evt("unexpected done");
                    else begin
                        e = exp_dn.pop_front();
                        check("done_rd", bus.done_rd, e.rd);
                        check("done_id", 32'(bus.done_id), 32'(e.id));
                    end
                    done_seen++;
                    dn_cyc = cyc;
                end
            end else begin
                bus.done_ready = 1'b1;
                hold = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [ID_W-1:0] id);
        int t;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_addr = addr; bus.req_rs2 = rs2; bus.req_id = id;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.req_ready !== 1'b1) fail_evt("req accept timeout");
        accept_cyc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_seen < done_target && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (done_seen < done_target) fail_evt("done timeout");
    endtask

    // One atomic: queue what the memory and writeback sides must see, then run it.
    task automatic run(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                       input bit ld, input bit st, input logic [31:0] st_data, input logic [31:0] rd);
        logic [ID_W-1:0] id;
        logic [31:0]     wa;
        id = next_id;
        next_id = next_id + 1'b1;
        wa = addr & 32'hFFFF_FFFC;
        if (ld) exp_ld.push_back(wa);
        if (st) exp_st.push_back('{wa, st_data});
        exp_dn.push_back('{rd, id});
        done_target++;
        issue(op, addr, rs2, id);
        wait_done();
    endtask

    task automatic pulse_snoop(input logic [31:0] addr);
        @(negedge clk);
        bus.snoop_valid = 1'b1; bus.snoop_addr = addr;
        @(negedge clk);
        bus.snoop_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_rs2 = '0; bus.req_id = '0;
        bus.snoop_valid = 1'b0; bus.snoop_addr = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("reset done_valid", 32'(bus.done_valid), 32'd0);
        check("reset mem_req_we", 32'(bus.mem_req_we), 32'd0);
        check("reset mem_req_addr", bus.mem_req_addr, 32'd0);
        check("reset mem_req_wdata", bus.mem_req_wdata, 32'd0);
        check("reset done_rd", bus.done_rd, 32'd0);
        check("reset done_id", 32'(bus.done_id), 32'd0);
        rst = 1'b0;

        mem[32'h100] = 32'd5;
        mem[32'h104] = 32'hDEAD_BEEF;
        mem[32'h108] = 32'hFF00_FF00;
        mem[32'h10C] = 32'h0000_0001;
        mem[32'h110] = 32'hFFFF_FFFF;
        mem[32'h200] = 32'h1111_1111;
        mem[32'h300] = 32'hFFFF_FFFF;
        mem[32'h400] = 32'h0000_00F0;
        mem[32'h500] = 32'hF0F0_F0F0;

        run(AMO_ADD, 32'h100, 32'd7, 1, 1, 32'd12, 32'd5);
        check("amoadd store cycle", 32'(st_cyc - accept_cyc), 32'd3);
        check("amoadd done cycle", 32'(dn_cyc - accept_cyc), 32'd4);

        run(AMO_MIN,  32'h300, 32'd1,         1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(AMO_MINU, 32'h300, 32'd1,         1, 1, 32'h0000_0001, 32'hFFFF_FFFF);
        run(AMO_MAX,  32'h300, 32'h8000_0000, 1, 1, 32'h0000_0001, 32'h0000_0001);
        run(AMO_MAXU, 32'h300, 32'h8000_0000, 1, 1, 32'h8000_0000, 32'h0000_0001);
        run(AMO_SWAP, 32'h104, 32'h1234_5678, 1, 1, 32'h1234_5678, 32'hDEAD_BEEF);
        run(AMO_AND,  32'h108, 32'h0F0F_0F0F, 1, 1, 32'h0F00_0F00, 32'hFF00_FF00);
        run(5'b00101, 32'h10C, 32'h0000_0055, 1, 1, 32'h0000_0055, 32'h0000_0001);
        run(AMO_ADD,  32'h112, 32'd2,         1, 1, 32'h0000_0001, 32'hFFFF_FFFF);

        run(AMO_LR, 32'h200, 32'd0, 1, 0, 32'd0, 32'h1111_1111);
        check("lr done cycle", 32'(dn_cyc - accept_cyc), 32'd3);
        run(AMO_SC, 32'h200, 32'hAB, 0, 1, 32'hAB, 32'd0);
        check("sc ok done cycle", 32'(dn_cyc - accept_cyc), 32'd3);
        run(AMO_SC, 32'h200, 32'hCD, 0, 0, 32'd0, 32'd1);
        check("sc fail done cycle", 32'(dn_cyc - accept_cyc), 32'd2);

        run(AMO_LR, 32'h200, 32'd0, 1, 0, 32'd0, 32'hAB);
        pulse_snoop(32'h202);
        run(AMO_SC, 32'h200, 32'hCD, 0, 0, 32'd0, 32'd1);

        run(AMO_LR, 32'h200, 32'd0, 1, 0, 32'd0, 32'hAB);
        pulse_flush();
        run(AMO_SC, 32'h200, 32'hCD, 0, 0, 32'd0, 32'd1);

        run(AMO_LR, 32'h200, 32'd0, 1, 0, 32'd0, 32'hAB);
        pulse_snoop(32'h300);
        run(AMO_SC, 32'h200, 32'hEE, 0, 1, 32'hEE, 32'd0);

        load_stall = 3; store_stall = 3; done_stall = 2;
        run(AMO_XOR, 32'h500, 32'hFF00_FF00, 1, 1, 32'h0FF0_0FF0, 32'hF0F0_F0F0);

        // Reset while the load response is outstanding.
        rsp_delay = 4;
        exp_ld.push_back(32'h400);
        issue(AMO_OR, 32'h400, 32'h0000_000F, next_id);
        t = 0;
        while (!load_pending && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!load_pending) fail_evt("load handshake timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-rst req_ready", 32'(bus.req_ready), 32'd1);
        check("post-rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("post-rst done_valid", 32'(bus.done_valid), 32'd0);
        repeat (6) @(negedge clk);
        check("late rsp ignored done_valid", 32'(bus.done_valid), 32'd0);
        check("late rsp ignored mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("late rsp ignored req_ready", 32'(bus.req_ready), 32'd1);
        rsp_delay = 1;
        run(AMO_OR, 32'h400, 32'h0000_000F, 1, 1, 32'h0000_00FF, 32'h0000_00F0);

        repeat (4) @(negedge clk);
        check("leftover stores", 32'(exp_st.size()), 32'd0);
        check("leftover loads", 32'(exp_ld.size()), 32'd0);
        check("leftover results", 32'(exp_dn.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
